// File: rtl/seg7_decoder.sv
// Recovers hex digits from a multiplexed, active-low 7-segment display bus.
// Each stable anode dwell captures one digit; four distinct digits form a frame.
module seg7_decoder #(
  parameter int unsigned SETTLE = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  anodos,
  input  logic [7:0]  segmentos,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic [3:0]  blank,
  output logic [3:0]  seg_err,
  output logic        frame_valid,
  output logic        anode_err
);

  localparam logic [3:0] SETTLE_MAX = 4'(SETTLE);
  localparam logic [3:0] SETTLE_M1  = 4'(SETTLE - 1);

  typedef enum logic [1:0] {SETTLING, CAPTURE, HOLD} state_t;

  state_t      state_q, state_d;
  logic [11:0] smp_q, smp_d;
  logic [11:0] prv_q, prv_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  mask_q, mask_d;
  logic [3:0]  wval_q [4];
  logic [3:0]  wval_d [4];
  logic [3:0]  wdp_q, wdp_d;
  logic [3:0]  wblank_q, wblank_d;
  logic [3:0]  werr_q, werr_d;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  dp_q, dp_d;
  logic [3:0]  blank_q, blank_d;
  logic [3:0]  seg_err_q, seg_err_d;
  logic        fv_q, fv_d;
  logic        anode_err_q, anode_err_d;

  logic        same;
  logic        capture;
  logic        one_hot;
  logic [3:0]  sel;
  logic [5:0]  dec;

  // Returns {blank, seg_err, value} for an a..g active-low pattern.
  function automatic logic [5:0] decode(input logic [6:0] pat);
    logic [5:0] r;
    case (pat)
      7'h01: r = 6'h00;
      7'h4F: r = 6'h01;
      7'h12: r = 6'h02;
      7'h06: r = 6'h03;
      7'h4C: r = 6'h04;
      7'h24: r = 6'h05;
      7'h20: r = 6'h06;
      7'h0F: r = 6'h07;
      7'h00: r = 6'h08;
      7'h04: r = 6'h09;
      7'h08: r = 6'h0A;
      7'h60: r = 6'h0B;
      7'h31: r = 6'h0C;
      7'h42: r = 6'h0D;
      7'h30: r = 6'h0E;
      7'h38: r = 6'h0F;
      7'h7F: r = 6'b10_0000;
      default: r = 6'b01_0000;
    endcase
    return r;
  endfunction

  always_comb begin
    smp_d       = {anodos, segmentos};
    prv_d       = smp_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    capture     = 1'b0;
    same        = (smp_q == prv_q);
    sel         = smp_q[11:8];
    one_hot     = (sel != 4'b0000) && ((sel & (sel - 4'd1)) == 4'b0000);
    dec         = decode(smp_q[7:1]);
    anode_err_d = anode_err_q;
    wdp_d       = wdp_q;
    wblank_d    = wblank_q;
    werr_d      = werr_q;
    for (int i = 0; i < 4; i++) wval_d[i] = wval_q[i];

    if (!same) begin
      state_d = SETTLING;
      cnt_d   = 4'd0;
    end else begin
      if (cnt_q != SETTLE_MAX) cnt_d = cnt_q + 4'd1;
      case (state_q)
        SETTLING: if (cnt_q == SETTLE_M1) begin
          state_d = CAPTURE;
          capture = 1'b1;
        end
        CAPTURE:  state_d = HOLD;
        default:  state_d = HOLD;
      endcase
    end

    // A completed frame clears the mask; a capture in the same cycle still lands.
    mask_d = (mask_q == 4'hF) ? 4'h0 : mask_q;

    if (capture) begin
      if (one_hot) begin
        for (int i = 0; i < 4; i++) begin
          if (sel[i]) begin
            wval_d[i]   = dec[3:0];
            wdp_d[i]    = ~smp_q[0];
            wblank_d[i] = dec[5];
            werr_d[i]   = dec[4];
            mask_d[i]   = 1'b1;
          end
        end
      end else begin
        anode_err_d = 1'b1;
      end
    end

    digits_d  = digits_q;
    dp_d      = dp_q;
    blank_d   = blank_q;
    seg_err_d = seg_err_q;
    fv_d      = 1'b0;
    if (mask_q == 4'hF) begin
      for (int i = 0; i < 4; i++) digits_d[4*i +: 4] = wval_q[i];
      dp_d      = wdp_q;
      blank_d   = wblank_q;
      seg_err_d = werr_q;
      fv_d      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= SETTLING;
      smp_q       <= '0;
      prv_q       <= '0;
      cnt_q       <= '0;
      mask_q      <= '0;
      wdp_q       <= '0;
      wblank_q    <= '0;
      werr_q      <= '0;
      digits_q    <= '0;
      dp_q        <= '0;
      blank_q     <= '0;
      seg_err_q   <= '0;
      fv_q        <= 1'b0;
      anode_err_q <= 1'b0;
      for (int i = 0; i < 4; i++) wval_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      smp_q       <= smp_d;
      prv_q       <= prv_d;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      wdp_q       <= wdp_d;
      wblank_q    <= wblank_d;
      werr_q      <= werr_d;
      digits_q    <= digits_d;
      dp_q        <= dp_d;
      blank_q     <= blank_d;
      seg_err_q   <= seg_err_d;
      fv_q        <= fv_d;
      anode_err_q <= anode_err_d;
      for (int i = 0; i < 4; i++) wval_q[i] <= wval_d[i];
    end
  end

  assign digits      = digits_q;
  assign dp          = dp_q;
  assign blank       = blank_q;
  assign seg_err     = seg_err_q;
  assign frame_valid = fv_q;
  assign anode_err   = anode_err_q;

endmodule

// File: tb/tb_seg7_decoder.sv
// Directed bench for seg7_decoder (SETTLE=3): frame assembly, latency,
// blank/dp/error flags, anode errors and mid-frame reset.
module tb_seg7_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  anodos;
  logic [7:0]  segmentos;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic [3:0]  seg_err;
  logic        frame_valid;
  logic        anode_err;

  int checks = 0;
  int errors = 0;
  int fv_count = 0;
  int fv_base;

  seg7_decoder #(.SETTLE(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .anodos      (anodos),
    .segmentos   (segmentos),
    .digits      (digits),
    .dp          (dp),
    .blank       (blank),
    .seg_err     (seg_err),
    .frame_valid (frame_valid),
    .anode_err   (anode_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_valid === 1'b1) fv_count++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-22s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Called at a falling edge; presents pins and waits n falling edges.
  task automatic drive(input logic [3:0] an, input logic [7:0] seg, input int n);
    anodos    = an;
    segmentos = seg;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_digits", 32'(digits), 32'h0);
    check("rst_dp", 32'(dp), 32'h0);
    check("rst_blank", 32'(blank), 32'h0);
    check("rst_seg_err", 32'(seg_err), 32'h0);
    check("rst_frame_valid", 32'(frame_valid), 32'h0);
    check("rst_anode_err", 32'(anode_err), 32'h0);
    rst = 1'b1;
  endtask

  initial begin
    rst       = 1'b0;
    anodos    = 4'b0000;
    segmentos = 8'hFF;
    @(negedge clk);
    do_reset();

    // Full rotation 0,1,2,3 with an exact latency check on the last digit.
    fv_base = fv_count;
    drive(4'b0001, 8'h03, 8);
    drive(4'b0010, 8'h9F, 8);
    drive(4'b0100, 8'h25, 8);
    drive(4'b1000, 8'h0D, 5);
    check("lat_fv_before", 32'(frame_valid), 32'h0);
    check("lat_digits_before", 32'(digits), 32'h0);
    @(negedge clk);
    check("lat_fv_pulse", 32'(frame_valid), 32'h1);
    check("rot_digits", 32'(digits), 32'h3210);
    @(negedge clk);
    check("lat_fv_one_cycle", 32'(frame_valid), 32'h0);
    @(negedge clk);
    check("rot_fv_count", 32'(fv_count - fv_base), 32'd1);
    check("rot_dp", 32'(dp), 32'h0);
    check("rot_blank", 32'(blank), 32'h0);
    check("rot_seg_err", 32'(seg_err), 32'h0);
    check("rot_anode_err", 32'(anode_err), 32'h0);

    // Two-cycle dwells are shorter than SETTLE allows: nothing is captured.
    fv_base = fv_count;
    for (int r = 0; r < 2; r++) begin
      drive(4'b0001, 8'h9F, 2);
      drive(4'b0010, 8'h25, 2);
      drive(4'b0100, 8'h0D, 2);
      drive(4'b1000, 8'h03, 2);
    end
    check("short_fv_count", 32'(fv_count - fv_base), 32'd0);
    check("short_digits_held", 32'(digits), 32'h3210);
    do_reset();

    // Blank, decimal point and undecodable patterns.
    // 0xFE has a..g all off with dp lit, so digit 0 is blank as well as digit 2.
    fv_base = fv_count;
    drive(4'b0001, 8'hFE, 8);
    drive(4'b0010, 8'h55, 8);
    drive(4'b0100, 8'hFF, 8);
    drive(4'b1000, 8'h9F, 8);
    check("flags_fv_count", 32'(fv_count - fv_base), 32'd1);
    check("flags_digits", 32'(digits), 32'h1000);
    check("flags_blank", 32'(blank), 32'b0101);
    check("flags_dp", 32'(dp), 32'b0001);
    check("flags_seg_err", 32'(seg_err), 32'b0010);

    // A stable two-hot anode sets anode_err and captures nothing.
    fv_base = fv_count;
    drive(4'b0100, 8'h25, 8);
    drive(4'b1000, 8'h0D, 8);
    drive(4'b0011, 8'h03, 8);
    check("anode_err_set", 32'(anode_err), 32'h1);
    check("anode_no_frame", 32'(fv_count - fv_base), 32'd0);
    check("anode_digits_held", 32'(digits), 32'h1000);
    drive(4'b0001, 8'h9F, 8);
    check("anode_mask_partial", 32'(fv_count - fv_base), 32'd0);
    drive(4'b0010, 8'h03, 8);
    check("anode_frame_done", 32'(fv_count - fv_base), 32'd1);
    check("anode_digits", 32'(digits), 32'h3201);
    check("anode_blank", 32'(blank), 32'h0);
    check("anode_seg_err", 32'(seg_err), 32'h0);
    check("anode_err_sticky", 32'(anode_err), 32'h1);

    // Reset mid-frame discards the two partial captures.
    drive(4'b0001, 8'h0D, 8);
    drive(4'b0010, 8'h25, 8);
    do_reset();
    fv_base = fv_count;
    drive(4'b0100, 8'h9F, 8);
    drive(4'b1000, 8'h03, 8);
    check("midrst_no_stale_frame", 32'(fv_count - fv_base), 32'd0);
    check("midrst_digits_clear", 32'(digits), 32'h0);
    drive(4'b0001, 8'h25, 8);
    check("midrst_three_of_four", 32'(fv_count - fv_base), 32'd0);
    drive(4'b0010, 8'h0D, 8);
    check("midrst_frame_done", 32'(fv_count - fv_base), 32'd1);
    check("midrst_digits", 32'(digits), 32'h0132);
    check("midrst_anode_err", 32'(anode_err), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
